// File: rtl/video_mon_pkg.sv
// video_mon_pkg: shared FSM state type and geometry constants for video_timing_monitor
package video_mon_pkg;
  localparam int CNT_W        = 16;
  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_ACTIVE_DEF = 1024;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
endpackage

// File: rtl/edge_det.sv
// edge_det: rise/fall detector comparing the input against its previous-cycle registered value
//   i_clk, i_rst (async, active-high), i_d  ->  o_rise, o_fall (combinational from i_d and r_prev)
module edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic r_prev;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_prev <= 1'b0;
    else r_prev <= i_d;
  assign o_rise = i_d & ~r_prev;
  assign o_fall = ~i_d & r_prev;
endmodule

// File: rtl/video_timing_monitor.sv
// video_timing_monitor: measures B2P line/frame geometry, locks on stable timing, forwards video one cycle late
//   clk_pixel_i, reset_i (async, active-high)
//   vsync_i, hsync_i, de_i, pd_i  -> vsync_o, hsync_o, de_o, pd_o (registered copies)
//   clr_err_i                     -> clears err_h_o / err_v_o
//   h_active_o, v_active_o, frame_cnt_o, locked_o : measurement and lock status
module video_timing_monitor
  import video_mon_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int PD_WIDTH    = 24,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                clk_pixel_i,
  input  logic                reset_i,
  input  logic                vsync_i,
  input  logic                hsync_i,
  input  logic                de_i,
  input  logic [PD_WIDTH-1:0] pd_i,
  input  logic                clr_err_i,
  output logic                vsync_o,
  output logic                hsync_o,
  output logic                de_o,
  output logic [PD_WIDTH-1:0] pd_o,
  output logic [CNT_W-1:0]    h_active_o,
  output logic [CNT_W-1:0]    v_active_o,
  output logic [CNT_W-1:0]    frame_cnt_o,
  output logic                locked_o,
  output logic                err_h_o,
  output logic                err_v_o
);
  state_t           r_state, w_next;
  logic [3:0]       r_good_cnt, w_good_next, w_good_inc;
  logic [CNT_W-1:0] r_pix_cnt, r_line_cnt, w_lines;
  logic             r_bad;
  logic             w_vs_rise, w_vs_fall_unused, w_de_rise, w_de_fall;
  logic             w_line_bad, w_height_bad, w_frame_bad;
  edge_det u_vs_edge (
    .i_clk (clk_pixel_i),
    .i_rst (reset_i),
    .i_d   (vsync_i),
    .o_rise(w_vs_rise),
    .o_fall(w_vs_fall_unused)
  );
  edge_det u_de_edge (
    .i_clk (clk_pixel_i),
    .i_rst (reset_i),
    .i_d   (de_i),
    .o_rise(w_de_rise),
    .o_fall(w_de_fall)
  );
  // A line ending in the vsync cycle still belongs to the frame that is closing.
  assign w_lines      = (w_de_fall && r_line_cnt != '1) ? r_line_cnt + CNT_W'(1) : r_line_cnt;
  assign w_line_bad   = w_de_fall && r_pix_cnt != CNT_W'(H_ACTIVE);
  // DE still high at vsync means the last line was cut short.
  assign w_height_bad = w_lines != CNT_W'(V_ACTIVE) || de_i;
  assign w_frame_bad  = r_bad || w_line_bad || w_height_bad;
  assign w_good_inc   = r_good_cnt + 4'd1;
  always_comb begin
    w_next      = r_state;
    w_good_next = r_good_cnt;
    if (w_vs_rise)
      case (r_state)
        SEARCH:  w_next = MEASURE;
        MEASURE: begin
          w_good_next = w_frame_bad ? '0 : w_good_inc;
          w_next      = (!w_frame_bad && w_good_inc >= 4'(LOCK_FRAMES)) ? LOCKED : MEASURE;
        end
        default: begin
          w_good_next = w_frame_bad ? '0 : r_good_cnt;
          w_next      = w_frame_bad ? MEASURE : LOCKED;
        end
      endcase
  end
  always_ff @(posedge clk_pixel_i or posedge reset_i)
    if (reset_i) begin
      r_state     <= SEARCH;
      r_good_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_line_cnt  <= '0;
      r_bad       <= 1'b0;
      vsync_o     <= 1'b0;
      hsync_o     <= 1'b0;
      de_o        <= 1'b0;
      pd_o        <= '0;
      h_active_o  <= '0;
      v_active_o  <= '0;
      frame_cnt_o <= '0;
      locked_o    <= 1'b0;
      err_h_o     <= 1'b0;
      err_v_o     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_good_cnt <= w_good_next;
      locked_o   <= w_next == LOCKED;
      vsync_o    <= vsync_i;
      hsync_o    <= hsync_i;
      de_o       <= de_i;
      pd_o       <= pd_i;
      // The rising-edge cycle is itself a DE cycle, so the count restarts at 1.
      if (w_de_rise) r_pix_cnt <= CNT_W'(1);
      else if (de_i && r_pix_cnt != '1) r_pix_cnt <= r_pix_cnt + CNT_W'(1);
      if (w_de_fall) h_active_o <= r_pix_cnt;
      r_line_cnt <= w_vs_rise ? '0 : w_lines;
      r_bad      <= w_vs_rise ? 1'b0 : (r_bad || w_line_bad);
      if (w_vs_rise && r_state != SEARCH) begin
        v_active_o  <= w_lines;
        frame_cnt_o <= frame_cnt_o + CNT_W'(1);
      end
      err_h_o <= (r_state == LOCKED && w_line_bad) || (err_h_o && !clr_err_i);
      err_v_o <= (r_state == LOCKED && w_vs_rise && w_height_bad) || (err_v_o && !clr_err_i);
    end
endmodule

// File: tb/tb_video_timing_monitor.sv
// tb_video_timing_monitor: randomized frame stimulus scored against a frame-level reference model
module tb_video_timing_monitor;
  localparam int H = 16, V = 8, LF = 2, PW = 24;
  logic          clk_pixel_i = 1'b0, reset_i = 1'b0;
  logic          vsync_i = 1'b0, hsync_i = 1'b0, de_i = 1'b0, clr_err_i = 1'b0;
  logic [PW-1:0] pd_i = '0;
  logic          vsync_o, hsync_o, de_o, locked_o, err_h_o, err_v_o;
  logic [PW-1:0] pd_o;
  logic [15:0]   h_active_o, v_active_o, frame_cnt_o;
  video_timing_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .PD_WIDTH(PW), .LOCK_FRAMES(LF)) dut (
    .clk_pixel_i(clk_pixel_i), .reset_i(reset_i), .vsync_i(vsync_i), .hsync_i(hsync_i),
    .de_i(de_i), .pd_i(pd_i), .clr_err_i(clr_err_i), .vsync_o(vsync_o), .hsync_o(hsync_o),
    .de_o(de_o), .pd_o(pd_o), .h_active_o(h_active_o), .v_active_o(v_active_o),
    .frame_cnt_o(frame_cnt_o), .locked_o(locked_o), .err_h_o(err_h_o), .err_v_o(err_v_o)
  );
  always #5 clk_pixel_i = ~clk_pixel_i;
  typedef struct {int len; bit eh;} line_exp_t;
  typedef struct {int vact; int fcnt; bit lk; bit ev;} frame_exp_t;
  typedef struct {int sel; longint exp; string name;} direct_t;
  line_exp_t  qh[$];
  frame_exp_t qv[$];
  direct_t    dq[$];
  int checks = 0, errors = 0;
  int st, good, lines, vact, fcnt, pend_len;
  bit bad, eh, ev, pend;
  task automatic model_reset();
    st = 0; good = 0; lines = 0; vact = 0; fcnt = 0; pend_len = 0;
    bad = 0; eh = 0; ev = 0; pend = 0;
  endtask
  task automatic model_line(int len);
    lines++;
    if (len != H) bad = 1;
    if (st == 2 && len != H) eh = 1;
    qh.push_back('{len > 65535 ? 65535 : len, eh});
  endtask
  task automatic model_frame(bit trunc);
    bit hb;
    hb = (lines != V) || trunc;
    if (st == 0) st = 1;
    else begin
      vact = lines;
      fcnt = (fcnt + 1) % 65536;
      if (st == 2 && hb) ev = 1;
      if (bad || hb) begin good = 0; st = 1; end
      else if (st == 1) begin good++; if (good >= LF) st = 2; end
    end
    lines = 0; bad = 0;
    qv.push_back('{vact, fcnt, st == 2, ev});
  endtask
  task automatic want(int s, longint e, string n);
    dq.push_back('{s, e, n});
  endtask
  task automatic cyc(bit vs, bit hs, bit de, bit clr);
    @(posedge clk_pixel_i);
    #1;
    vsync_i = vs; hsync_i = hs; de_i = de; clr_err_i = clr; pd_i = PW'($urandom);
    if (pend) begin
      if (de) pend_len++;
      else begin pend = 0; model_line(pend_len); end
    end
  endtask
  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask
  task automatic drive_line(int len);
    cyc(0, 1, 0, 0);
    idle($urandom_range(1, 2));
    repeat (len) cyc(0, 0, 1, 0);
    pend = 1; pend_len = len;
  endtask
  task automatic drive_frame(int nl, int bad_line, int bad_len, bit coinc);
    for (int i = 0; i < nl; i++) drive_line(i == bad_line ? bad_len : H);
    if (!coinc) idle($urandom_range(1, 3));
  endtask
  task automatic drive_vsync(bit keep_de);
    cyc(1, 0, keep_de, 0);
    model_frame(keep_de);
    cyc(1, 0, 0, 0);
    idle($urandom_range(1, 3));
  endtask
  task automatic pulse_clr();
    idle(1);
    cyc(0, 0, 0, 1);
    eh = 0; ev = 0;
    cyc(0, 0, 0, 0);
  endtask
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [63:0] sel_val(int s);
    return s == 0 ? 64'(locked_o) : s == 1 ? 64'(h_active_o) : s == 2 ? 64'(v_active_o) :
           s == 3 ? 64'(err_h_o) : s == 4 ? 64'(err_v_o) : s == 5 ? 64'(frame_cnt_o) :
           s == 6 ? 64'(qh.size()) : 64'(qv.size());
  endfunction
  logic          pv = 0, pdeo = 0, pvso = 0, pvs, phs, pde;
  logic [PW-1:0] ppd;
  line_exp_t     le;
  frame_exp_t    fe;
  direct_t       dc;
  always @(negedge clk_pixel_i) begin
    if (reset_i) begin
      chk("reset_ctl", {vsync_o, hsync_o, de_o, locked_o, err_h_o, err_v_o, pd_o}, 0);
      chk("reset_cnt", {h_active_o, v_active_o, frame_cnt_o}, 0);
      pv = 0; pdeo = 0; pvso = 0;
    end else begin
      if (pv) chk("passthrough", {vsync_o, hsync_o, de_o, pd_o}, {pvs, phs, pde, ppd});
      if (pdeo && !de_o) begin
        if (qh.size() == 0) begin
          checks++; errors++;
          $display("FAIL line_event: got h_active %0d, expected no line end", h_active_o);
        end else begin
          le = qh.pop_front();
          chk("h_active", 64'(h_active_o), 64'(le.len));
          chk("err_h", 64'(err_h_o), 64'(le.eh));
        end
      end
      if (!pvso && vsync_o) begin
        if (qv.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_event: got v_active %0d, expected no frame end", v_active_o);
        end else begin
          fe = qv.pop_front();
          chk("v_active", 64'(v_active_o), 64'(fe.vact));
          chk("frame_cnt", 64'(frame_cnt_o), 64'(fe.fcnt));
          chk("locked", 64'(locked_o), 64'(fe.lk));
          chk("err_v", 64'(err_v_o), 64'(fe.ev));
        end
      end
      while (dq.size() != 0) begin
        dc = dq.pop_front();
        chk(dc.name, sel_val(dc.sel), 64'(dc.exp));
      end
      pvs = vsync_i; phs = hsync_i; pde = de_i; ppd = pd_i;
      pv = 1; pdeo = de_o; pvso = vsync_o;
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  int r;
  initial begin
    model_reset();
    #2 reset_i = 1;
    repeat (2) @(posedge clk_pixel_i);
    #1 reset_i = 0;
    drive_vsync(0);
    repeat (2) begin drive_frame(V, -1, 0, 0); drive_vsync(0); end
    want(0, 1, "lock_3rd_vsync"); want(1, H, "h_at_lock"); want(2, V, "v_at_lock");
    want(3, 0, "eh_at_lock"); want(4, 0, "ev_at_lock"); want(5, 2, "fcnt_at_lock");
    drive_frame(V, 3, H - 1, 0);
    want(3, 1, "eh_short_line"); want(0, 1, "lock_holds_midframe");
    drive_vsync(0);
    want(0, 0, "unlock_short_line");
    repeat (2) begin drive_frame(V, -1, 0, 1); drive_vsync(0); end
    want(0, 1, "relock_coincident"); want(2, V, "v_coincident");
    drive_frame(V - 1, -1, 0, 0);
    drive_vsync(0);
    want(2, V - 1, "v_short_frame"); want(4, 1, "ev_short_frame"); want(0, 0, "unlock_short_frame");
    pulse_clr();
    want(3, 0, "eh_cleared"); want(4, 0, "ev_cleared");
    repeat (24) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin drive_frame(V, -1, 0, 1'($urandom_range(0, 1))); drive_vsync(0); end
      else if (r == 6) begin
        drive_frame(V, $urandom_range(0, V - 1), $urandom_range(1, H + 3), 1'($urandom_range(0, 1)));
        drive_vsync(0);
      end else if (r == 7) begin
        drive_frame($urandom_range(0, 1) ? V - 1 : V + 1, -1, 0, 1'($urandom_range(0, 1)));
        drive_vsync(0);
      end else if (r == 8) begin drive_frame(V, -1, 0, 1); drive_vsync(1); end
      else begin pulse_clr(); drive_frame(V, -1, 0, 0); drive_vsync(0); end
    end
    for (int k = 0; k < 6 && st != 2; k++) begin drive_frame(V, -1, 0, 0); drive_vsync(0); end
    want(0, 1, "locked_before_reset");
    drive_frame(5, -1, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (4) cyc(0, 0, 1, 0);
    #2 reset_i = 1;
    vsync_i = 0; hsync_i = 0; de_i = 0; clr_err_i = 0;
    model_reset();
    repeat (2) @(posedge clk_pixel_i);
    #1 reset_i = 0;
    drive_vsync(0);
    drive_frame(V, -1, 0, 0);
    drive_vsync(0);
    want(0, 0, "not_locked_2nd_vsync");
    drive_frame(V, -1, 0, 0);
    drive_vsync(0);
    want(0, 1, "relock_after_reset"); want(5, 2, "fcnt_after_reset");
    idle(3);
    want(6, 0, "line_queue_drained"); want(7, 0, "frame_queue_drained");
    @(negedge clk_pixel_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
